// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the five-stage MIPS core.
package pipe_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic valid;
    logic alusrc;
    logic regwr;
    logic memrd;
    logic memwr;
    logic memtoreg;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded slot in, execute register and front-end holds out.
interface id_ex_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);
  import pipe_pkg::*;

  logic                D_Valid;
  logic [REG_W-1:0]    D_Rs, D_Rt, D_Rd;
  logic                D_UsesRs, D_UsesRt, D_RegDst;
  logic                D_ALUSrc, D_RegWr, D_MemRd, D_MemWr, D_MemtoReg;
  logic [ALUOP_W-1:0]  D_ALUOp;
  logic [DW-1:0]       D_busA, D_busB, D_Imm32, D_PC;
  logic                Flush;

  logic                E_Valid, E_ALUSrc, E_RegWr, E_MemRd, E_MemWr, E_MemtoReg;
  logic [REG_W-1:0]    E_Rs, E_Rt, E_Rw;
  logic [ALUOP_W-1:0]  E_ALUOp;
  logic [DW-1:0]       E_busA, E_busB, E_Imm32, E_PC;
  logic                PC_Wr, D_Wr;
  logic [CW-1:0]       StallCnt, FlushCnt;

  modport master (
    output D_Valid, D_Rs, D_Rt, D_Rd, D_UsesRs, D_UsesRt, D_RegDst,
           D_ALUSrc, D_RegWr, D_MemRd, D_MemWr, D_MemtoReg, D_ALUOp,
           D_busA, D_busB, D_Imm32, D_PC, Flush,
    input  E_Valid, E_ALUSrc, E_RegWr, E_MemRd, E_MemWr, E_MemtoReg,
           E_Rs, E_Rt, E_Rw, E_ALUOp, E_busA, E_busB, E_Imm32, E_PC,
           PC_Wr, D_Wr, StallCnt, FlushCnt
  );

  modport slave (
    input  D_Valid, D_Rs, D_Rt, D_Rd, D_UsesRs, D_UsesRt, D_RegDst,
           D_ALUSrc, D_RegWr, D_MemRd, D_MemWr, D_MemtoReg, D_ALUOp,
           D_busA, D_busB, D_Imm32, D_PC, Flush,
    output E_Valid, E_ALUSrc, E_RegWr, E_MemRd, E_MemWr, E_MemtoReg,
           E_Rs, E_Rt, E_Rw, E_ALUOp, E_busA, E_busB, E_Imm32, E_PC,
           PC_Wr, D_Wr, StallCnt, FlushCnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: an in-flight load whose destination the decode slot reads.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             e_valid_i,
  input  logic             e_memrd_i,
  input  logic             e_regwr_i,
  input  logic [REG_W-1:0] e_rw_i,
  input  logic             d_valid_i,
  input  logic             d_uses_rs_i,
  input  logic             d_uses_rt_i,
  input  logic [REG_W-1:0] d_rs_i,
  input  logic [REG_W-1:0] d_rt_i,
  output logic             hazard_c_o
);

  assign hazard_c_o = e_valid_i && e_memrd_i && e_regwr_i && (e_rw_i != REG_ZERO) &&
                      d_valid_i &&
                      ((d_uses_rs_i && (d_rs_i == e_rw_i)) ||
                       (d_uses_rt_i && (d_rt_i == e_rw_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating event counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  io
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  ex_ctrl_t            ctrl_q, ctrl_d;
  logic [REG_W-1:0]    rs_q, rs_d, rt_q, rt_d, rw_q, rw_d;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [DW-1:0]       busa_q, busa_d, busb_q, busb_d, imm_q, imm_d, pc_q, pc_d;
  logic [CW-1:0]       stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                hazard_c, stall_c, bubble_c;

  load_use_detect u_lud (
    .e_valid_i   (ctrl_q.valid),
    .e_memrd_i   (ctrl_q.memrd),
    .e_regwr_i   (ctrl_q.regwr),
    .e_rw_i      (rw_q),
    .d_valid_i   (io.D_Valid),
    .d_uses_rs_i (io.D_UsesRs),
    .d_uses_rt_i (io.D_UsesRt),
    .d_rs_i      (io.D_Rs),
    .d_rt_i      (io.D_Rt),
    .hazard_c_o  (hazard_c)
  );

  // A flush outranks a stall: the slot is squashed anyway, so the front end must move on.
  assign stall_c  = hazard_c && !io.Flush;
  assign bubble_c = hazard_c || io.Flush;

  always_comb begin
    ctrl_d      = EX_BUBBLE;
    rs_d        = '0;
    rt_d        = '0;
    rw_d        = '0;
    aluop_d     = '0;
    busa_d      = '0;
    busb_d      = '0;
    imm_d       = '0;
    pc_d        = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // Invalid slots load normally but never write or look like a load.
    if (!bubble_c) begin
      ctrl_d.valid    = io.D_Valid;
      ctrl_d.alusrc   = io.D_ALUSrc;
      ctrl_d.regwr    = io.D_RegWr && io.D_Valid;
      ctrl_d.memrd    = io.D_MemRd && io.D_Valid;
      ctrl_d.memwr    = io.D_MemWr && io.D_Valid;
      ctrl_d.memtoreg = io.D_MemtoReg;
      rs_d            = io.D_Rs;
      rt_d            = io.D_Rt;
      rw_d            = io.D_RegDst ? io.D_Rd : io.D_Rt;
      aluop_d         = io.D_ALUOp;
      busa_d          = io.D_busA;
      busb_d          = io.D_busB;
      imm_d           = io.D_Imm32;
      pc_d            = io.D_PC;
    end

    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
    if (io.Flush && io.D_Valid && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= EX_BUBBLE;
      rs_q        <= '0;
      rt_q        <= '0;
      rw_q        <= '0;
      aluop_q     <= '0;
      busa_q      <= '0;
      busb_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rw_q        <= rw_d;
      aluop_q     <= aluop_d;
      busa_q      <= busa_d;
      busb_q      <= busb_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign io.E_Valid    = ctrl_q.valid;
  assign io.E_ALUSrc   = ctrl_q.alusrc;
  assign io.E_RegWr    = ctrl_q.regwr;
  assign io.E_MemRd    = ctrl_q.memrd;
  assign io.E_MemWr    = ctrl_q.memwr;
  assign io.E_MemtoReg = ctrl_q.memtoreg;
  assign io.E_Rs       = rs_q;
  assign io.E_Rt       = rt_q;
  assign io.E_Rw       = rw_q;
  assign io.E_ALUOp    = aluop_q;
  assign io.E_busA     = busa_q;
  assign io.E_busB     = busb_q;
  assign io.E_Imm32    = imm_q;
  assign io.E_PC       = pc_q;
  assign io.PC_Wr      = !stall_c;
  assign io.D_Wr       = !stall_c;
  assign io.StallCnt   = stall_cnt_q;
  assign io.FlushCnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/reset scenarios plus random traffic vs a rule model.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .CW(CW)) io ();

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rs, uses_rt, regdst;
    logic        alusrc, regwr, memrd, memwr, memtoreg;
    logic [3:0]  aluop;
    logic [31:0] busa, busb, imm, pc;
  } d_t;

  typedef struct {
    logic        valid, alusrc, regwr, memrd, memwr, memtoreg;
    logic [4:0]  rs, rt, rw;
    logic [3:0]  aluop;
    logic [31:0] busa, busb, imm, pc;
  } e_t;

  e_t m_e;
  int m_stall, m_flush;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic e_t empty_e();
    e_t e;
    e.valid = 0; e.alusrc = 0; e.regwr = 0; e.memrd = 0; e.memwr = 0; e.memtoreg = 0;
    e.rs = 0; e.rt = 0; e.rw = 0; e.aluop = 0;
    e.busa = 0; e.busb = 0; e.imm = 0; e.pc = 0;
    return e;
  endfunction

  function automatic d_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic urs, input logic urt, input logic rdst,
                            input logic wr, input logic rd_mem);
    d_t d;
    d.valid = 1; d.rs = rs; d.rt = rt; d.rd = rd;
    d.uses_rs = urs; d.uses_rt = urt; d.regdst = rdst;
    d.alusrc = rd_mem; d.regwr = wr; d.memrd = rd_mem; d.memwr = 0; d.memtoreg = rd_mem;
    d.aluop = rd_mem ? 4'd2 : 4'd5;
    d.busa = $urandom; d.busb = $urandom; d.imm = $urandom; d.pc = $urandom;
    return d;
  endfunction

  function automatic d_t rand_d();
    d_t d;
    d.valid = ($urandom_range(0, 3) != 0);
    d.rs = 5'($urandom_range(0, 3)); d.rt = 5'($urandom_range(0, 3));
    d.rd = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) d.rd = 5'($urandom_range(0, 31));
    d.uses_rs = 1'($urandom); d.uses_rt = 1'($urandom); d.regdst = 1'($urandom);
    d.alusrc = 1'($urandom); d.regwr = 1'($urandom); d.memrd = 1'($urandom);
    d.memwr = 1'($urandom); d.memtoreg = 1'($urandom);
    d.aluop = 4'($urandom);
    d.busa = $urandom; d.busb = $urandom; d.imm = $urandom; d.pc = $urandom;
    return d;
  endfunction

  // A load in execute whose nonzero destination the decode slot actually reads.
  function automatic logic load_use(input d_t d);
    logic reads_it;
    reads_it = (d.uses_rs && d.rs == m_e.rw) || (d.uses_rt && d.rt == m_e.rw);
    return m_e.valid && m_e.memrd && m_e.regwr && m_e.rw != 0 && d.valid && reads_it;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_e(input string tag);
    chk({tag, ".E_Valid"},    32'(io.E_Valid),    32'(m_e.valid));
    chk({tag, ".E_ALUSrc"},   32'(io.E_ALUSrc),   32'(m_e.alusrc));
    chk({tag, ".E_RegWr"},    32'(io.E_RegWr),    32'(m_e.regwr));
    chk({tag, ".E_MemRd"},    32'(io.E_MemRd),    32'(m_e.memrd));
    chk({tag, ".E_MemWr"},    32'(io.E_MemWr),    32'(m_e.memwr));
    chk({tag, ".E_MemtoReg"}, 32'(io.E_MemtoReg), 32'(m_e.memtoreg));
    chk({tag, ".E_Rs"},       32'(io.E_Rs),       32'(m_e.rs));
    chk({tag, ".E_Rt"},       32'(io.E_Rt),       32'(m_e.rt));
    chk({tag, ".E_Rw"},       32'(io.E_Rw),       32'(m_e.rw));
    chk({tag, ".E_ALUOp"},    32'(io.E_ALUOp),    32'(m_e.aluop));
    chk({tag, ".E_busA"},     io.E_busA,          m_e.busa);
    chk({tag, ".E_busB"},     io.E_busB,          m_e.busb);
    chk({tag, ".E_Imm32"},    io.E_Imm32,         m_e.imm);
    chk({tag, ".E_PC"},       io.E_PC,            m_e.pc);
    chk({tag, ".StallCnt"},   32'(io.StallCnt),   32'(m_stall));
    chk({tag, ".FlushCnt"},   32'(io.FlushCnt),   32'(m_flush));
  endtask

  task automatic apply(input d_t d, input logic fl);
    io.D_Valid = d.valid; io.D_Rs = d.rs; io.D_Rt = d.rt; io.D_Rd = d.rd;
    io.D_UsesRs = d.uses_rs; io.D_UsesRt = d.uses_rt; io.D_RegDst = d.regdst;
    io.D_ALUSrc = d.alusrc; io.D_RegWr = d.regwr; io.D_MemRd = d.memrd;
    io.D_MemWr = d.memwr; io.D_MemtoReg = d.memtoreg; io.D_ALUOp = d.aluop;
    io.D_busA = d.busa; io.D_busB = d.busb; io.D_Imm32 = d.imm; io.D_PC = d.pc;
    io.Flush = fl;
  endtask

  // One cycle: drive the slot, check the front-end hold, clock, then check the E register.
  task automatic step(input string tag, input d_t d, input logic fl);
    logic haz, stall;
    apply(d, fl);
    #1;
    haz   = load_use(d);
    stall = haz && !fl;
    chk({tag, ".PC_Wr"}, 32'(io.PC_Wr), 32'(!stall));
    chk({tag, ".D_Wr"},  32'(io.D_Wr),  32'(!stall));
    @(posedge clk); #1;
    if (stall) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (fl && d.valid) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    if (fl || haz) begin
      m_e = empty_e();
    end else begin
      m_e.valid = d.valid; m_e.alusrc = d.alusrc; m_e.memtoreg = d.memtoreg;
      m_e.regwr = d.regwr && d.valid; m_e.memrd = d.memrd && d.valid;
      m_e.memwr = d.memwr && d.valid;
      m_e.rs = d.rs; m_e.rt = d.rt; m_e.rw = d.regdst ? d.rd : d.rt;
      m_e.aluop = d.aluop; m_e.busa = d.busa; m_e.busb = d.busb;
      m_e.imm = d.imm; m_e.pc = d.pc;
    end
    check_e(tag);
  endtask

  task automatic model_reset();
    m_e = empty_e(); m_stall = 0; m_flush = 0;
  endtask

  initial begin
    d_t zero_d, lw8, add98, lw0, add_0, addi_rt8, lwchain;

    zero_d = mk(0, 0, 0, 0, 0, 0, 0, 0);
    zero_d.valid = 0; zero_d.aluop = 0;
    zero_d.busa = 0; zero_d.busb = 0; zero_d.imm = 0; zero_d.pc = 0;
    lw8      = mk(5'd29, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    add98    = mk(5'd8, 5'd10, 5'd9, 1, 1, 1, 1, 0);
    lw0      = mk(5'd29, 5'd0, 5'd0, 1, 0, 0, 1, 1);
    add_0    = mk(5'd0, 5'd0, 5'd11, 1, 1, 1, 1, 0);
    addi_rt8 = mk(5'd0, 5'd8, 5'd0, 1, 0, 0, 1, 0);
    addi_rt8.rt = 5'd8; addi_rt8.regdst = 0;
    lwchain  = mk(5'd8, 5'd8, 5'd0, 1, 0, 0, 1, 1);

    // Reset with everything idle.
    model_reset();
    apply(zero_d, 0);
    repeat (2) @(posedge clk);
    #1;
    check_e("reset");
    chk("reset.PC_Wr", 32'(io.PC_Wr), 32'd1);
    chk("reset.D_Wr",  32'(io.D_Wr),  32'd1);
    rst_n = 1'b1;
    step("idle", zero_d, 0);

    // Load-use: one stall, bubble, then the consumer loads.
    step("lw8", lw8, 0);
    step("add_stall", add98, 0);
    chk("add_stall.bubble_valid", 32'(io.E_Valid), 32'd0);
    chk("add_stall.cnt", 32'(io.StallCnt), 32'd1);
    step("add_load", add98, 0);
    chk("add_load.E_Rs", 32'(io.E_Rs), 32'd8);
    chk("add_load.E_Rw", 32'(io.E_Rw), 32'd9);

    // Destination $0 never stalls.
    step("lw0", lw0, 0);
    step("add_0", add_0, 0);
    chk("add_0.E_Valid", 32'(io.E_Valid), 32'd1);

    // Matching Rt that is not read does not stall.
    step("lw8b", lw8, 0);
    step("addi_rt8", addi_rt8, 0);
    chk("addi_rt8.cnt", 32'(io.StallCnt), 32'd1);

    // Hazard and flush together: bubble, no stall, flush counted.
    step("lw8c", lw8, 0);
    step("haz_flush", add98, 1);
    chk("haz_flush.cnt_stall", 32'(io.StallCnt), 32'd1);
    chk("haz_flush.cnt_flush", 32'(io.FlushCnt), 32'd1);

    // Reset asserted in the middle of a stall.
    step("lw8d", lw8, 0);
    apply(add98, 0);
    #1;
    chk("mid.PC_Wr_held", 32'(io.PC_Wr), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_e("mid_rst");
    chk("mid_rst.PC_Wr", 32'(io.PC_Wr), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", add98, 0);

    // Random traffic, hazards encouraged by a narrow register range.
    for (int i = 0; i < 300; i++) begin
      step("rand", rand_d(), ($urandom_range(0, 7) == 0));
    end

    // Stall-counter saturation via a chain of dependent loads.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * ((1 << CW) + 3); i++) begin
      step("sat", lwchain, 0);
    end
    chk("sat.StallCnt", 32'(io.StallCnt), 32'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
